// File: rtl/disp_pkg.sv
// Shared types and constants for the countdown display sequencer.
package disp_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned OP_W    = 3;

    // Operation symbol codes understood by the seven-segment driver
    localparam logic [OP_W-1:0] OP_T = OP_W'(0);
    localparam logic [OP_W-1:0] OP_A = OP_W'(1);
    localparam logic [OP_W-1:0] OP_C = OP_W'(2);
    localparam logic [OP_W-1:0] OP_B = OP_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYMBOL = 2'd1,
        ST_COUNT  = 2'd2
    } state_e;

    // Control payload presented to the seven-segment driver
    typedef struct packed {
        logic               en;
        logic               disp_mode;
        logic [OP_W-1:0]    op_code;
        logic [DIGIT_W-1:0] digit_val;
    } disp_ctrl_t;

endpackage

// File: rtl/countdown_disp_ctrl_if.sv
// Request / display-control bundle between the requester and the sequencer.
interface countdown_disp_ctrl_if;
    import disp_pkg::*;

    logic               i_start;
    logic [OP_W-1:0]    i_op_code;
    logic [DIGIT_W-1:0] i_count;
    logic               i_abort;
    logic               o_busy;
    logic               o_done;
    logic               o_en;
    logic               o_disp_mode;
    logic [OP_W-1:0]    o_op_code;
    logic [DIGIT_W-1:0] o_digit_val;

    // Requester side
    modport master (
        output i_start, i_op_code, i_count, i_abort,
        input  o_busy, o_done, o_en, o_disp_mode, o_op_code, o_digit_val
    );

    // Sequencer side
    modport slave (
        input  i_start, i_op_code, i_count, i_abort,
        output o_busy, o_done, o_en, o_disp_mode, o_op_code, o_digit_val
    );
endinterface

// File: rtl/tick_prescaler.sv
// Clear-able 0..limit-1 counter with terminal-count pulse and half-period flag.
// half_c reflects the count value that will be held after the coming edge,
// so a consumer can register it alongside its own next-state.
module tick_prescaler #(
    parameter  int unsigned MAX_CNT = 8,
    localparam int unsigned CW      = $clog2(MAX_CNT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [CW-1:0] limit,
    output logic          tc_c,
    output logic          half_c
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap on terminal count, hold at zero while cleared
    always_comb begin
        tc_c   = (cnt_q == (limit - CW'(1)));
        cnt_d  = (clr || tc_c) ? '0 : (cnt_q + CW'(1));
        half_c = (cnt_d >= (limit >> 1));
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_disp_ctrl.sv
// Countdown display sequencer: shows an op symbol, then counts a digit down
// once per second, pulsing done on expiry.
// Optional feature macro: COUNTDOWN_BLINK_EN (blink the display during the
// last four seconds of the countdown).
module countdown_disp_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned SYM_CYC = 100_000_000,
    parameter int unsigned SEC_CYC = 100_000_000
) (
    input logic                  clk,
    input logic                  rst_n,
    countdown_disp_ctrl_if.slave bus
);

    localparam int unsigned PRE_MAX = (SYM_CYC > SEC_CYC) ? SYM_CYC : SEC_CYC;
    localparam int unsigned LIM_W   = $clog2(PRE_MAX + 1);

    state_e     state_q;
    state_e     state_d;
    disp_ctrl_t disp_q;
    disp_ctrl_t disp_d;
    logic       busy_q;
    logic       busy_d;
    logic       done_q;
    logic       done_d;

    logic [LIM_W-1:0] limit_c;
    logic             pre_clr_c;
    logic             pre_tc_c;
    logic             pre_half_c;

    // One prescaler shared by both timed states; its limit follows the state
    assign limit_c   = (state_q == ST_SYMBOL) ? LIM_W'(SYM_CYC) : LIM_W'(SEC_CYC);
    assign pre_clr_c = (state_q == ST_IDLE) || bus.i_abort;

    tick_prescaler #(
        .MAX_CNT (PRE_MAX)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (pre_clr_c),
        .limit  (limit_c),
        .tc_c   (pre_tc_c),
        .half_c (pre_half_c)
    );

`ifndef COUNTDOWN_BLINK_EN
    logic unused_pre_half;
    assign unused_pre_half = pre_half_c;
`endif

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;

        if (bus.i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_d          = ST_SYMBOL;
                        disp_d.op_code   = bus.i_op_code;
                        disp_d.digit_val = bus.i_count;
                    end
                end
                ST_SYMBOL: begin
                    if (pre_tc_c) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (pre_tc_c) begin
                        if (disp_q.digit_val != '0) begin
                            disp_d.digit_val = disp_q.digit_val - DIGIT_W'(1);
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d           = (state_d != ST_IDLE);
        disp_d.disp_mode = (state_d == ST_COUNT);
        disp_d.en        = busy_d;
`ifdef COUNTDOWN_BLINK_EN
        if ((state_d == ST_COUNT) && (disp_d.digit_val <= DIGIT_W'(3)) && pre_half_c) begin
            disp_d.en = 1'b0;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            disp_q <= disp_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_en        = disp_q.en;
    assign bus.o_disp_mode = disp_q.disp_mode;
    assign bus.o_op_code   = disp_q.op_code;
    assign bus.o_digit_val = disp_q.digit_val;

endmodule

// File: tb/tb_countdown_disp_ctrl.sv
// Self-checking bench for countdown_disp_ctrl against an elapsed-time model.
module tb_countdown_disp_ctrl;
    import disp_pkg::*;

    localparam int unsigned SYM = 4;
    localparam int unsigned SEC = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    countdown_disp_ctrl_if bus ();

    countdown_disp_ctrl #(
        .SYM_CYC (SYM),
        .SEC_CYC (SEC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed cycles since the accepted start
    bit          m_active;
    int          m_t;
    int          m_cnt;
    logic [2:0]  m_op;
    logic        m_done;
    logic        m_en;
    logic        m_mode;
    logic [2:0]  m_opv;
    logic [3:0]  m_val;
    logic [10:0] exp_v;
    logic [10:0] got_v;

    function automatic logic [10:0] sample();
        return {bus.o_busy, bus.o_done, bus.o_en, bus.o_disp_mode, bus.o_op_code, bus.o_digit_val};
    endfunction

    task automatic model_reset();
        m_active = 0; m_t = 0; m_cnt = 0; m_op = '0; m_done = 0;
        m_en = 0; m_mode = 0; m_opv = '0; m_val = '0;
        exp_v = '0;
    endtask

    task automatic model_eval();
        int u;
        if (m_active) begin
            m_opv = m_op;
            m_en  = 1'b1;
            if (m_t < int'(SYM)) begin
                m_mode = 1'b0;
                m_val  = 4'(m_cnt);
            end else begin
                u      = m_t - int'(SYM);
                m_mode = 1'b1;
                m_val  = 4'(m_cnt - u / int'(SEC));
`ifdef COUNTDOWN_BLINK_EN
                if (m_val <= 4'd3 && (u % int'(SEC)) >= int'(SEC / 2)) m_en = 1'b0;
`endif
            end
        end else begin
            m_en   = 1'b0;
            m_mode = 1'b0;
        end
        exp_v = {m_active, m_done, m_en, m_mode, m_opv, m_val};
    endtask

    // Drive one cycle of inputs, advance the model over the edge, sample after it
    task automatic step(input logic st, input logic [2:0] op, input logic [3:0] c, input logic ab);
        @(negedge clk);
        bus.i_start   = st;
        bus.i_op_code = op;
        bus.i_count   = c;
        bus.i_abort   = ab;
        @(posedge clk);
        m_done = 1'b0;
        if (ab) begin
            m_active = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_t = 0; m_op = op; m_cnt = int'(c);
            end
        end else begin
            m_t++;
            if (m_t >= int'(SYM) + (m_cnt + 1) * int'(SEC)) begin
                m_active = 0;
                m_done   = 1'b1;
            end
        end
        model_eval();
        #1;
        got_v = sample();
    endtask

    task automatic drive_idle_inputs();
        bus.i_start = 1'b0; bus.i_op_code = '0; bus.i_count = '0; bus.i_abort = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        got_v = sample();
        checks++;
        if (got_v !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", got_v, 11'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int busy_cyc = 0;
        int done_cnt = 0;
        step(1'b1, OP_A, 4'd2, 1'b0);
        for (int i = 0; i < 34; i++) begin
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL basic cyc%0d: got %b want %b", i, got_v, exp_v);
            end
            busy_cyc += int'(got_v[10]);
            done_cnt += int'(got_v[9]);
            step(1'b0, '0, '0, 1'b0);
        end
        checks++;
        if (busy_cyc != 28) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d want 28", busy_cyc);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_zero_count();
        step(1'b1, OP_C, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL zero_count cyc%0d: got %b want %b", i, got_v, exp_v);
            end
            step(1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_abort();
        int i;
        step(1'b1, OP_B, 4'd2, 1'b0);
        i = 0;
        while (!(m_mode && m_val == 4'd1) && i < 40) begin
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL abort_run cyc%0d: got %b want %b", i, got_v, exp_v);
            end
            step(1'b0, '0, '0, 1'b0);
            i++;
        end
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        checks++;
        if (got_v !== {4'b0000, 3'(OP_B), 4'd1}) begin
            errors++;
            $display("FAIL abort_idle: got %b want %b", got_v, {4'b0000, 3'(OP_B), 4'd1});
        end
        for (int k = 0; k < 3 + int'(SYM) + 2 * int'(SEC) + 3; k++) begin
            step((k == 3) ? 1'b1 : 1'b0, 3'd6, 4'd1, 1'b0);
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL abort_restart cyc%0d: got %b want %b", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_start_ignored();
        step(1'b1, OP_A, 4'd3, 1'b0);
        for (int i = 0; i < int'(SYM) + 4 * int'(SEC) + 3; i++) begin
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL start_ignored cyc%0d: got %b want %b", i, got_v, exp_v);
            end
            step((i == 10 || i == 2) ? 1'b1 : 1'b0, 3'd7, 4'd9, 1'b0);
        end
    endtask

    task automatic test_start_abort_idle();
        step(1'b1, 3'd5, 4'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_v[10] !== 1'b0 || got_v !== exp_v) begin
                errors++;
                $display("FAIL start_abort_idle cyc%0d: got %b want %b", i, got_v, exp_v);
            end
            step(1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_symbol();
        step(1'b1, OP_C, 4'd5, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL mid_symbol_pre: got %b want %b", got_v, exp_v);
        end
        drive_idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        got_v = sample();
        model_reset();
        checks++;
        if (got_v !== 11'd0) begin
            errors++;
            $display("FAIL mid_symbol_reset: got %b want %b", got_v, 11'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b0);
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL post_reset cyc%0d: got %b want %b", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic st, ab;
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(0, 9) == 0);
            ab = ($urandom_range(0, 59) == 0);
            step(st, 3'($urandom), 4'($urandom), ab);
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc%0d: got %b want %b", i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_zero_count();
        test_abort();
        test_start_ignored();
        test_start_abort_idle();
        test_reset_mid_symbol();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
